// File: rtl/ex_mem_skid_pkg.sv
// rtl/ex_mem_skid_pkg.sv - shared state encodings and NOP constants for the EX/MEM skid register
package ex_mem_skid_pkg;

  // Occupancy of the two-entry skid register
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  // Destination address presented while no entry is valid
  localparam int unsigned NOP_ADDR = 0;

  // Packed payload: {wd, wdata, wreg, whilo, hi, lo}
  function automatic int unsigned payload_width(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + 3 * data_w + 2;
  endfunction

endpackage

// File: rtl/ex_mem_skid_if.sv
// rtl/ex_mem_skid_if.sv - EX-side and MEM-side handshake bundle for the skid register
interface ex_mem_skid_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  import ex_mem_skid_pkg::*;

  logic              flush;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_wd;
  logic [DATA_W-1:0] in_wdata;
  logic              in_wreg;
  logic              in_whilo;
  logic [DATA_W-1:0] in_hi;
  logic [DATA_W-1:0] in_lo;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_wd;
  logic [DATA_W-1:0] out_wdata;
  logic              out_wreg;
  logic              out_whilo;
  logic [DATA_W-1:0] out_hi;
  logic [DATA_W-1:0] out_lo;

  modport slave (
    input  flush,
    input  in_valid, in_wd, in_wdata, in_wreg, in_whilo, in_hi, in_lo,
    output in_ready,
    output out_valid, out_wd, out_wdata, out_wreg, out_whilo, out_hi, out_lo,
    input  out_ready
  );

  modport master (
    output flush,
    output in_valid, in_wd, in_wdata, in_wreg, in_whilo, in_hi, in_lo,
    input  in_ready,
    input  out_valid, out_wd, out_wdata, out_wreg, out_whilo, out_hi, out_lo,
    output out_ready
  );

endinterface

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - two-entry EX/MEM skid register with registered in_ready
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  ex_mem_skid_if.slave bus
);

  localparam int PW = payload_width(ADDR_W, DATA_W);

  skid_state_t   r_state;
  skid_state_t   w_state_nxt;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic          r_in_ready;

  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;
  logic          w_load_main_in;
  logic          w_load_main_skid;
  logic          w_load_skid;
  logic          w_clear;
  logic [PW-1:0] w_in_payload;
  logic [PW-1:0] w_nop_payload;
  logic [PW-1:0] w_out_payload;

  assign w_in_payload  = {bus.in_wd, bus.in_wdata, bus.in_wreg, bus.in_whilo, bus.in_hi, bus.in_lo};
  assign w_nop_payload = {ADDR_W'(NOP_ADDR), {(PW - ADDR_W){1'b0}}};
  assign w_out_valid   = (r_state != ST_EMPTY);
  assign w_push        = bus.in_valid & r_in_ready;
  assign w_pop         = w_out_valid & bus.out_ready;

  // Occupancy state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_state_nxt;
  end

  // Next occupancy and which entry loads what; flush overrides push and pop
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clear          = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_push && !w_pop) begin
            w_load_skid = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_push && w_pop) begin
            w_load_main_in = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_in_ready <= 1'b0;
    else      r_in_ready <= (w_state_nxt != ST_FULL);
  end

  // Main and skid entry storage; skid drains into main on a pop from FULL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (w_clear) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in)        r_main <= w_in_payload;
      else if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= w_in_payload;
    end
  end

  assign w_out_payload = w_out_valid ? r_main : w_nop_payload;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_lo    = w_out_payload[DATA_W-1:0];
  assign bus.out_hi    = w_out_payload[2*DATA_W-1:DATA_W];
  assign bus.out_whilo = w_out_payload[2*DATA_W];
  assign bus.out_wreg  = w_out_payload[2*DATA_W+1];
  assign bus.out_wdata = w_out_payload[3*DATA_W+1:2*DATA_W+2];
  assign bus.out_wd    = w_out_payload[PW-1:3*DATA_W+2];

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - scoreboard bench for the EX/MEM skid register
module tb_ex_mem_skid;
  import ex_mem_skid_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic [DATA_W-1:0] wdata;
    logic              wreg;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  ent_t exp_q[$];

  always #5 clk = ~clk;

  ex_mem_skid_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ex_mem_skid #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input int wd);
    ent_t e;
    e.wd    = ADDR_W'(wd);
    e.wdata = 32'h1000_0000 + 32'(wd) * 32'd17;
    e.wreg  = 1'(wd);
    e.whilo = 1'(wd >> 1);
    e.hi    = ~e.wdata;
    e.lo    = e.wdata ^ 32'h5A5A_5A5A;
    return e;
  endfunction

  // One cycle of stimulus; expected entry is queued when the handshake completes
  task automatic step(input bit v, input ent_t e, input bit ordy);
    bus.in_valid  = v;
    bus.in_wd     = e.wd;
    bus.in_wdata  = e.wdata;
    bus.in_wreg   = e.wreg;
    bus.in_whilo  = e.whilo;
    bus.in_hi     = e.hi;
    bus.in_lo     = e.lo;
    bus.out_ready = ordy;
    @(negedge clk);
    if (v && bus.in_ready) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: presented entry must match the scoreboard head, or be NOP when invalid
  always @(negedge clk) begin : monitor
    ent_t act;
    act = {bus.out_wd, bus.out_wdata, bus.out_wreg, bus.out_whilo, bus.out_hi, bus.out_lo};
    if (mon_en) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 128'(act), 128'(0));
          chk("unexpected_out_valid", 128'(1), 128'(0));
        end else begin
          chk("out_entry", 128'(act), 128'(exp_q[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("nop_out", 128'(act), 128'(0));
      end
    end
  end

  initial begin
    ent_t e;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_wd     = '0;
    bus.in_wdata  = '0;
    bus.in_wreg   = 1'b0;
    bus.in_whilo  = 1'b0;
    bus.in_hi     = '0;
    bus.in_lo     = '0;
    bus.out_ready = 1'b0;

    #1 rst = 1'b0;
    #1 mon_en = 1'b1;
    chk("reset_in_ready", 128'(bus.in_ready), 128'(0));
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("pre_edge_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk);
    #1 chk("first_edge_in_ready", 128'(bus.in_ready), 128'(1));

    // Streaming wd=1..8 with one-cycle latency
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, mk(i), 1'b1);
      chk("stream_out_valid", 128'(bus.out_valid), 128'(1));
      chk("stream_out_wd", 128'(bus.out_wd), 128'(i));
      chk("stream_in_ready", 128'(bus.in_ready), 128'(1));
    end
    step(1'b0, '0, 1'b1);
    chk("stream_drained", 128'(bus.out_valid), 128'(0));

    // Backpressure fills the skid, then drains in order
    step(1'b1, mk(3), 1'b0);
    step(1'b1, mk(4), 1'b0);
    chk("bp_full_in_ready", 128'(bus.in_ready), 128'(0));
    chk("bp_full_out_wd", 128'(bus.out_wd), 128'(3));
    step(1'b0, '0, 1'b0);
    chk("bp_hold_out_wd", 128'(bus.out_wd), 128'(3));
    step(1'b0, '0, 1'b1);
    chk("bp_pop_in_ready", 128'(bus.in_ready), 128'(1));
    chk("bp_pop_out_wd", 128'(bus.out_wd), 128'(4));
    step(1'b0, '0, 1'b1);
    chk("bp_empty", 128'(bus.out_valid), 128'(0));

    // Push and pop together in ONE
    step(1'b1, mk(6), 1'b0);
    chk("sim_first_wd", 128'(bus.out_wd), 128'(6));
    step(1'b1, mk(7), 1'b1);
    chk("sim_out_valid", 128'(bus.out_valid), 128'(1));
    chk("sim_out_wd", 128'(bus.out_wd), 128'(7));
    chk("sim_in_ready_one", 128'(bus.in_ready), 128'(1));
    step(1'b0, '0, 1'b1);

    // FULL with pressure from both sides: order 10, 11, 12
    step(1'b1, mk(10), 1'b0);
    step(1'b1, mk(11), 1'b0);
    step(1'b1, mk(12), 1'b1);
    chk("full_pop_wd", 128'(bus.out_wd), 128'(11));
    step(1'b1, mk(12), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("full_drain_empty", 128'(bus.out_valid), 128'(0));

    // Flush while FULL with a push offered
    step(1'b1, mk(20), 1'b0);
    step(1'b1, mk(21), 1'b0);
    e = mk(9);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_wd     = e.wd;
    bus.in_wdata  = e.wdata;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_out_wd", 128'(bus.out_wd), 128'(0));
    chk("flush_out_wdata", 128'(bus.out_wdata), 128'(0));
    chk("flush_in_ready", 128'(bus.in_ready), 128'(1));
    step(1'b1, mk(22), 1'b1);
    chk("post_flush_wd", 128'(bus.out_wd), 128'(22));
    step(1'b0, '0, 1'b1);

    // Asynchronous reset while FULL with HI/LO writes
    e = mk(30);
    e.whilo = 1'b1;
    e.hi    = 32'hDEAD_BEEF;
    step(1'b1, e, 1'b0);
    e = mk(31);
    e.whilo = 1'b1;
    e.hi    = 32'hDEAD_BEEF;
    step(1'b1, e, 1'b0);
    chk("rst_pre_hi", 128'(bus.out_hi), 128'(32'hDEAD_BEEF));
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_hi", 128'(bus.out_hi), 128'(0));
    chk("rst_out_whilo", 128'(bus.out_whilo), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_rel_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk);
    #1;
    chk("rst_edge_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_edge_out_valid", 128'(bus.out_valid), 128'(0));
    step(1'b1, mk(5), 1'b1);
    chk("post_rst_wd", 128'(bus.out_wd), 128'(5));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 Parameter ADDR_W, default 5: destination register address width.
REQ-002 Parameter DATA_W, default 32: data, HI and LO width.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port flush, input, 1: synchronous discard of all held entries.
REQ-006 Ports in_valid (input, 1) and in_ready (output, 1): upstream (EX) handshake.
REQ-007 Port in_wd, input, ADDR_W: destination address. Port in_wdata, input, DATA_W: write data. Port in_wreg, input, 1: register write enable.
REQ-008 Port in_whilo, input, 1: HI/LO write enable. Ports in_hi and in_lo, input, DATA_W each: HI and LO values.
REQ-009 Ports out_valid (output, 1) and out_ready (input, 1): downstream (MEM) handshake.
REQ-010 Ports out_wd, out_wdata, out_wreg, out_whilo, out_hi and out_lo, outputs, widths matching their in_* counterparts: presented entry.

Function
REQ-011 The block SHALL be a two-entry skid register: a main entry drives the outputs and a skid entry holds overflow.
REQ-012 Occupancy SHALL be tracked by a state machine with states EMPTY, ONE and FULL.
REQ-013 in_ready SHALL be driven directly from a register and SHALL be 1 unless the state is FULL; no combinational path from out_ready to in_ready is allowed.
REQ-014 A push SHALL occur when in_valid and in_ready are both 1. A pop SHALL occur when out_valid and out_ready are both 1.
REQ-015 From EMPTY, a push SHALL load the main entry and move to ONE; with no push the state SHALL stay EMPTY.
REQ-016 From ONE, the transitions SHALL be:
- push with no pop: load the skid entry, move to FULL;
- push with pop: load the main entry, stay in ONE;
- pop only: move to EMPTY;
- neither: hold.
REQ-017 From FULL, a pop SHALL move the skid entry into the main entry and move to ONE; with no pop the state SHALL hold.
REQ-018 Entries SHALL leave in arrival order, with no loss and no duplication.
REQ-019 Latency SHALL be one cycle: a push at edge N is visible on out_* after edge N. Sustained throughput SHALL be one entry per cycle while out_ready=1.
REQ-020 out_valid SHALL be 1 exactly in states ONE and FULL.
REQ-021 While out_valid=0, the outputs SHALL present NOP values: out_wd=0, out_wdata=0, out_wreg=0, out_whilo=0, out_hi=0, out_lo=0.
REQ-022 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-023 flush=1 SHALL take priority over push and pop: the state goes to EMPTY at the next edge and any simultaneous push is dropped.
REQ-024 Payload fields SHALL pass through unmodified, with no width conversion.

Reset
REQ-025 While rst=0, the state SHALL be EMPTY, both entries zero, in_ready=0, out_valid=0 and all out_* at NOP values, asynchronously.
REQ-026 After rst rises, in_ready SHALL become 1 at the first clk edge.
REQ-027 Reset asserted mid-transfer SHALL discard all held entries, including a FULL skid.

Structure
REQ-028 The state encodings and the NOP address constant SHALL reside in the shared defines file.
REQ-029 Payload SHALL be packed internally into one bus of width ADDR_W+3*DATA_W+2; no sub-module is required.

Verification
REQ-030 Streaming: send wd=1..8 with in_valid=1 and out_ready=1 -> out_wd=1..8 on consecutive cycles with one-cycle latency and in_ready held at 1.
REQ-031 Backpressure: out_ready=0, push A (wd=3) then B (wd=4) -> state FULL, in_ready=0, out_wd=3 held. Then out_ready=1 -> outputs 3 then 4, and in_ready returns to 1.
REQ-032 Simultaneous events in ONE: push wd=7 while popping wd=6 -> state stays ONE and out_wd=7 at the next cycle.
REQ-033 Flush: in FULL, assert flush with in_valid=1 -> next cycle out_valid=0, outputs zero, and the pushed entry never appears.
REQ-034 Reset: assert rst=0 asynchronously between edges while FULL with whilo=1, hi=32'hDEADBEEF -> outputs zero immediately; after release, in_ready=1 at the first edge.
